hex_cmd_framer: RTL

Sequencing controller for the ASCII-to-hex-nibble datapath in the temperature-monitor UART command path.
- Accepts the raw UART RX byte stream and feeds each byte through an instantiated ASCII-to-nibble converter.
- Frames the stream as "#" + ADDR_DIGITS hex chars + DATA_DIGITS hex chars + CR (0x0D).
- Assembles the nibbles into an address/data command and pulses cmd_vld, or flags cmd_err.
- Downstream: register-write decoder (alarm thresholds, sample period).

---
 rtl/hex_cmd_framer_pkg.sv | 20 ++
 rtl/hex_cmd_framer_conv.sv | 29 ++
 rtl/hex_cmd_framer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hex_cmd_framer_pkg.sv
// Shared constants and types for the temperature-monitor UART command path.
package temp_mon_pkg;

  localparam logic [7:0] CH_SOF = 8'h23;
  localparam logic [7:0] CH_EOF = 8'h0D;

  localparam int unsigned DEF_ADDR_DIGITS = 2;
  localparam int unsigned DEF_DATA_DIGITS = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TERM} state_t;

  // Digit counter must index the longer of the two fields; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned d);
    int unsigned m;
    m = (a > d) ? a : d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/hex_cmd_framer_conv.sv
// hex_digit_conv: ASCII '0'-'9','A'-'F','a'-'f' to nibble, one cycle of latency.
module hex_digit_conv (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_vld,
  output logic [3:0] o_nib,
  output logic       o_nib_vld
);

  logic w_is_dig;
  logic w_is_alpha;

  assign w_is_dig   = (i_byte >= 8'h30) && (i_byte <= 8'h39);
  assign w_is_alpha = ((i_byte >= 8'h41) && (i_byte <= 8'h46)) ||
                      ((i_byte >= 8'h61) && (i_byte <= 8'h66));

  // Letters of either case share the low nibble 1..6, so value = low nibble + 9.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_nib     <= '0;
      o_nib_vld <= 1'b0;
    end else begin
      o_nib     <= w_is_dig ? i_byte[3:0] : (i_byte[3:0] + 4'd9);
      o_nib_vld <= i_vld && (w_is_dig || w_is_alpha);
    end
  end

endmodule

// File: rtl/hex_cmd_framer.sv
// Frames "#" + address hex + data hex + CR into a register-write command.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module hex_cmd_framer
  import temp_mon_pkg::*;
#(
  parameter int unsigned ADDR_DIGITS = DEF_ADDR_DIGITS,
  parameter int unsigned DATA_DIGITS = DEF_DATA_DIGITS,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 din,
  input  logic                       din_vld,
  output logic [4*ADDR_DIGITS-1:0]   cmd_addr,
  output logic [4*DATA_DIGITS-1:0]   cmd_data,
  output logic                       cmd_vld,
  output logic                       cmd_err,
  output logic                       busy
);

  localparam int unsigned AW = 4 * ADDR_DIGITS;
  localparam int unsigned DW = 4 * DATA_DIGITS;
  localparam int unsigned CW = cnt_width(ADDR_DIGITS, DATA_DIGITS);

  state_t          r_state, w_state_n;
  logic [7:0]      r_byte_d;
  logic            r_vld_d;
  logic [AW-1:0]   r_addr_sh, w_addr_sh_n;
  logic [DW-1:0]   r_data_sh, w_data_sh_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [AW-1:0]   w_cmd_addr_n;
  logic [DW-1:0]   w_cmd_data_n;
  logic            w_vld_n, w_err_n;
  logic [3:0]      w_nib;
  logic            w_nib_vld;
  logic            w_hex, w_sof, w_eof;
  logic            w_timeout;

  hex_digit_conv u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_byte    (din),
    .i_vld     (din_vld),
    .o_nib     (w_nib),
    .o_nib_vld (w_nib_vld)
  );

  assign w_hex = r_vld_d && w_nib_vld;
  assign w_sof = r_vld_d && (r_byte_d == CH_SOF);
  assign w_eof = r_vld_d && (r_byte_d == CH_EOF);

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;

  // An arriving byte wins over an expiring timer in the same cycle.
  assign w_timeout = !r_vld_d && (r_state != IDLE) && (r_to_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_to_cnt <= '0;
    else if (r_vld_d || (r_state == IDLE) || w_timeout) r_to_cnt <= '0;
    else                                             r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_addr_sh_n  = r_addr_sh;
    w_data_sh_n  = r_data_sh;
    w_cnt_n      = r_cnt;
    w_cmd_addr_n = cmd_addr;
    w_cmd_data_n = cmd_data;
    w_vld_n      = 1'b0;
    w_err_n      = 1'b0;
    if (r_vld_d) begin
      // SOF outside IDLE reports the aborted frame and restarts in one step.
      if (w_sof) begin
        w_err_n     = (r_state != IDLE);
        w_state_n   = ADDR;
        w_addr_sh_n = '0;
        w_data_sh_n = '0;
        w_cnt_n     = '0;
      end else begin
        case (r_state)
          IDLE: ;
          ADDR: begin
            if (w_hex) begin
              w_addr_sh_n = (r_addr_sh << 4) | AW'(w_nib);
              if (r_cnt == CW'(ADDR_DIGITS - 1)) begin
                w_cnt_n   = '0;
                w_state_n = DATA;
              end else begin
                w_cnt_n = r_cnt + 1'b1;
              end
            end else begin
              w_err_n   = 1'b1;
              w_state_n = IDLE;
            end
          end
          DATA: begin
            if (w_hex) begin
              w_data_sh_n = (r_data_sh << 4) | DW'(w_nib);
              if (r_cnt == CW'(DATA_DIGITS - 1)) begin
                w_cnt_n   = '0;
                w_state_n = TERM;
              end else begin
                w_cnt_n = r_cnt + 1'b1;
              end
            end else begin
              w_err_n   = 1'b1;
              w_state_n = IDLE;
            end
          end
          TERM: begin
            if (w_eof) begin
              w_cmd_addr_n = r_addr_sh;
              w_cmd_data_n = r_data_sh;
              w_vld_n      = 1'b1;
            end else begin
              w_err_n = 1'b1;
            end
            w_state_n = IDLE;
          end
          default: w_state_n = IDLE;
        endcase
      end
    end else if (w_timeout) begin
      w_err_n   = 1'b1;
      w_state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_byte_d  <= '0;
      r_vld_d   <= 1'b0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_cnt     <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_vld   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_byte_d  <= din;
      r_vld_d   <= din_vld;
      r_addr_sh <= w_addr_sh_n;
      r_data_sh <= w_data_sh_n;
      r_cnt     <= w_cnt_n;
      cmd_addr  <= w_cmd_addr_n;
      cmd_data  <= w_cmd_data_n;
      cmd_vld   <= w_vld_n;
      cmd_err   <= w_err_n;
    end
  end

  assign busy = (r_state != IDLE);

endmodule
